// File: rtl/hazard_if.sv
// Hazard scheduler bundle: pipeline status in, control and counters out.
// The master drives the status; the slave is the scheduler.
interface hazard_if #(
  parameter int CNT_W = 32
);
  logic [31:0]      inst_ID;
  logic [4:0]       rd_EX;
  logic             memRead_EX;
  logic             regWEn_EX;
  logic             br_taken_EX;
  logic             dmem_req_MEM;
  logic             dmem_ack;
  logic             stall_IF;
  logic             stall_ID;
  logic             stall_EX;
  logic             stall_MEM;
  logic             flush_ID;
  logic             flush_EX;
  logic             bubble_WB;
  logic             mem_timeout;
  logic [CNT_W-1:0] stall_cnt;
  logic [CNT_W-1:0] flush_cnt;

  modport master (
    output inst_ID, rd_EX, memRead_EX, regWEn_EX,
    output br_taken_EX, dmem_req_MEM, dmem_ack,
    input  stall_IF, stall_ID, stall_EX, stall_MEM,
    input  flush_ID, flush_EX, bubble_WB,
    input  mem_timeout, stall_cnt, flush_cnt
  );

  modport slave (
    input  inst_ID, rd_EX, memRead_EX, regWEn_EX,
    input  br_taken_EX, dmem_req_MEM, dmem_ack,
    output stall_IF, stall_ID, stall_EX, stall_MEM,
    output flush_ID, flush_EX, bubble_WB,
    output mem_timeout, stall_cnt, flush_cnt
  );
endinterface

// File: rtl/hazard_scheduler.sv
// Pipeline hazard scheduler: load-use stalls, branch flushes,
// data-memory wait freezes with timeout, and perf counters.
module hazard_scheduler #(
  parameter int MEM_TIMEOUT = 255,
  parameter int CNT_W       = 32
) (
  input logic     i_clk,
  input logic     i_reset,
  hazard_if.slave hif
);

  localparam int WW =
    (MEM_TIMEOUT < 2) ? 1 : $clog2(MEM_TIMEOUT + 1);
  localparam logic [WW-1:0] TMO = WW'(MEM_TIMEOUT);

  localparam logic [6:0] OP_LUI   = 7'b0110111;
  localparam logic [6:0] OP_AUIPC = 7'b0010111;
  localparam logic [6:0] OP_JAL   = 7'b1101111;
  localparam logic [6:0] OP_R     = 7'b0110011;
  localparam logic [6:0] OP_S     = 7'b0100011;
  localparam logic [6:0] OP_B     = 7'b1100011;

  typedef enum logic [1:0] {
    RUN,
    LU_STALL,
    MEM_WAIT
  } state_e;

  state_e           state_q, state_d;
  logic [WW-1:0]    wait_q, wait_d;
  logic             tmo_q, tmo_d;
  logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
  logic [CNT_W-1:0] flush_cnt_q, flush_cnt_d;

  logic [6:0] opc;
  logic [4:0] rs1;
  logic [4:0] rs2;
  logic       use_rs1;
  logic       use_rs2;
  logic       load_use;
  logic       mem_busy;
  logic       mem_done;
  logic       frz;
  logic       st_ifid;
  logic       fl_id;
  logic       fl_ex;
  logic       unused_inst;

  assign opc = hif.inst_ID[6:0];
  assign rs1 = hif.inst_ID[19:15];
  assign rs2 = hif.inst_ID[24:20];
  assign unused_inst =
    ^{hif.inst_ID[31:25], hif.inst_ID[14:7]};

  // Decode which source registers the ID instruction reads.
  always_comb begin
    use_rs1 = 1'b1;
    use_rs2 = 1'b0;
    if (opc == OP_LUI || opc == OP_AUIPC || opc == OP_JAL)
      use_rs1 = 1'b0;
    if (opc == OP_R || opc == OP_S || opc == OP_B)
      use_rs2 = 1'b1;
  end

  assign load_use = hif.memRead_EX & hif.regWEn_EX
                  & (hif.rd_EX != 5'd0)
                  & ((use_rs1 & (hif.rd_EX == rs1))
                   | (use_rs2 & (hif.rd_EX == rs2)));

  // An ack is only meaningful alongside a live request.
  assign mem_busy = hif.dmem_req_MEM & ~hif.dmem_ack;
  assign mem_done = hif.dmem_req_MEM & hif.dmem_ack;

  // Next state and control decisions, memory > branch > load-use.
  always_comb begin
    state_d = state_q;
    frz     = 1'b0;
    st_ifid = 1'b0;
    fl_id   = 1'b0;
    fl_ex   = 1'b0;
    unique case (state_q)
      RUN: begin
        if (mem_busy) begin
          frz     = 1'b1;
          state_d = MEM_WAIT;
        end else if (hif.br_taken_EX) begin
          fl_id = 1'b1;
          fl_ex = 1'b1;
        end else if (load_use) begin
          st_ifid = 1'b1;
          fl_ex   = 1'b1;
          state_d = LU_STALL;
        end
      end
      LU_STALL: begin
        if (mem_busy) begin
          frz     = 1'b1;
          state_d = MEM_WAIT;
        end else begin
          state_d = RUN;
        end
      end
      MEM_WAIT: begin
        if (mem_done) state_d = RUN;
        else          frz     = 1'b1;
      end
      default: state_d = RUN;
    endcase
    if (i_reset) begin
      state_d = RUN;
      frz     = 1'b0;
      st_ifid = 1'b0;
      fl_id   = 1'b0;
      fl_ex   = 1'b0;
    end
  end

  assign hif.stall_IF    = frz | st_ifid;
  assign hif.stall_ID    = frz | st_ifid;
  assign hif.stall_EX    = frz;
  assign hif.stall_MEM   = frz;
  assign hif.bubble_WB   = frz;
  assign hif.flush_ID    = fl_id;
  assign hif.flush_EX    = fl_ex;
  assign hif.mem_timeout = tmo_q;
  assign hif.stall_cnt   = stall_cnt_q;
  assign hif.flush_cnt   = flush_cnt_q;

  // Wait counter, sticky timeout and wrapping perf counters.
  always_comb begin
    wait_d      = wait_q;
    tmo_d       = tmo_q;
    stall_cnt_d = stall_cnt_q + CNT_W'(hif.stall_IF);
    flush_cnt_d = flush_cnt_q
                + CNT_W'(hif.flush_ID | hif.flush_EX);
    if (state_q != MEM_WAIT && state_d == MEM_WAIT) begin
      wait_d = '0;
    end else if (state_q == MEM_WAIT) begin
      wait_d = (wait_q >= TMO) ? wait_q : wait_q + 1'b1;
      if (wait_d >= TMO) tmo_d = 1'b1;
    end
  end

  // State register with synchronous reset.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state_q     <= RUN;
      wait_q      <= '0;
      tmo_q       <= 1'b0;
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      wait_q      <= wait_d;
      tmo_q       <= tmo_d;
      stall_cnt_q <= stall_cnt_d;
      flush_cnt_q <= flush_cnt_d;
    end
  end

endmodule
